fc2_score_buffer: RTL and testbench
===================================

Name: fc2_score_buffer

Overview:
- Producer end of the FC2-score read interface. Accepts the 10 FC2 accumulator results as a valid/ready stream.
- Requantizes each result to 8-bit unsigned and stores it in a register-based score buffer.
- Pulses frame_done to start the argmax decision stage, then serves that stage's rd_addr/rd_data reads with BRAM-style 1-cycle latency.
- Holds the frame stable until the decision stage releases it.

Parameters:
- NUM_CLASSES, 10, number of scores per frame (buffer depth).
- ACC_W, 24, width of signed accumulator input.
- SHIFT, 4, arithmetic right shift applied before saturation.
- ADDR_W, 10, read-address width (matches decision-stage rd_addr).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  accumulator word valid.
- in_ready  out  1  buffer accepts word; high only in FILL.
- in_data  in  ACC_W  signed accumulator result, class order 0..NUM_CLASSES-1.
- frame_done  out  1  one-cycle pulse: full frame stored; drives decision-stage start.
- release  in  1  pulse from decision stage (its done); frees buffer for next frame.
- rd_addr  in  ADDR_W  score index requested by decision stage.
- rd_data  out  8  registered score, 1-cycle latency.

Behaviour:
- Reset: rst sampled low at posedge → state FILL, write count 0, all NUM_CLASSES entries 0, rd_data 0, frame_done 0, in_ready 1 from the next cycle. Reset mid-frame discards partial data.
- Requant: q = in_data >>> SHIFT (sign-preserving). Score = 0 if q<0; 255 if q>255; else q[7:0]. Intermediate width is ACC_W, so there is no overflow before the clamp.
- FSM FILL:
  - in_ready=1.
  - Handshake = in_valid & in_ready. On each handshake, entry[count] ← score at that edge and count increments.
  - Handshake with count==NUM_CLASSES-1 → count ← 0, state SIGNAL.
  - release is ignored in FILL.
- FSM SIGNAL:
  - Lasts one cycle. in_ready=0, frame_done=1.
  - Next state HOLD.
  - frame_done is registered and is high exactly in the cycle after the last handshake edge.
- FSM HOLD:
  - in_ready=0. in_valid is ignored, and the producer must hold its word.
  - release=1 → FILL next cycle. in_ready rises the cycle after release is sampled.
  - release in the SIGNAL cycle is honoured, same as in HOLD.
- Read port:
  - Every posedge: rd_data ← entry[rd_addr] if rd_addr < NUM_CLASSES, else 8'd0.
  - Reads are legal in any state. In FILL, a read returns the current (possibly partial) contents.
  - Write and read of the same entry on the same edge → rd_data gets the old value.
- Buffer contents persist across frames until overwritten or reset. They are not cleared on release.

Optional Feature:
- Macro: FC2_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_flag (1 bit).
  - sat_flag is cleared at the first handshake of a frame (count==0).
  - It is set sticky if any handshake in the frame clamped, i.e. q<0 or q>255.
  - It is valid from the frame_done cycle until the next frame's first handshake. Reset value 0.
- Undefined: port and logic absent; scores are identical in both builds.

Test Plan:
- Nominal frame (SHIFT=4):
  - Stimulus: 10 words back-to-back; entries 0–9 = 160 except idx3=2400, idx7=3200.
  - Response: frame_done pulses one cycle after the 10th handshake.
  - Reads addr 0..9 return 10,10,10,150,10,10,10,200,10,10, each one cycle after the address.
  - Decision stage reports class 7.
- Saturation:
  - Stimulus: words 8000, −500, 4095, 4096, 15.
  - Response: scores 255, 0, 255, 255, 0 (4095>>>4=255, 4096>>>4=256→255, 15→0).
  - With FC2_SAT_FLAG_EN: sat_flag=1 at frame_done. A clean frame gives sat_flag=0.
- Backpressure:
  - Stimulus: after frame_done, hold in_valid=1 with value 1600 for 20 cycles.
  - Response: in_ready=0 throughout and entries unchanged.
  - Pulse release → in_ready=1 the next cycle; the held word is written to entry 0 as 100.
- Out-of-range read: rd_addr=12 and rd_addr=1023 → rd_data=0 next cycle.
- Reset mid-fill:
  - Stimulus: 4 handshakes, then rst=0 for 1 cycle.
  - Response: rd_data=0, all entries read 0, frame_done stays 0.
  - A subsequent full 10-word frame gives exactly one frame_done pulse with correct scores.
- Read/write collision: in FILL, read addr 2 on the edge entry 2 is written → old value returned; re-read gives new value.

Source files
------------

// File: rtl/fc2_score_buffer.sv
// fc2_score_buffer: producer end of the FC2-score read interface.
// Accepts NUM_CLASSES signed accumulator words over valid/ready, requantizes
// each word to 8-bit unsigned, stores the frame, pulses frame_done and then
// serves 1-cycle-latency reads until the decision stage frees the frame.
// The decision stage's release pulse enters on frame_release because
// "release" is a reserved word in SystemVerilog.
// Optional feature macro: FC2_SAT_FLAG_EN (adds the sticky sat_flag output).
module fc2_score_buffer #(
   parameter int NUM_CLASSES = 10,
   parameter int ACC_W       = 24,
   parameter int SHIFT       = 4,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ACC_W-1:0]  in_data,
   output logic              frame_done,
   input  logic              frame_release,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
`ifdef FC2_SAT_FLAG_EN
   ,
   output logic              sat_flag
`endif
);

   localparam int CNT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

   typedef enum logic [1:0] {
      FILL,
      SIGNAL,
      HOLD
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [CNT_W-1:0]         count;
   logic [7:0]               entry [NUM_CLASSES];
   logic                     hs;
   logic                     last;
   logic signed [ACC_W-1:0]  q;
   logic                     clamp_lo;
   logic                     clamp_hi;
   logic [7:0]               score;
   logic                     rd_in_range;
   logic [CNT_W-1:0]         rd_idx;

   assign hs          = in_valid && (state_q == FILL);
   assign last        = (count == CNT_W'(NUM_CLASSES - 1));
   assign rd_in_range = (rd_addr < ADDR_W'(NUM_CLASSES));
   assign rd_idx      = rd_addr[CNT_W-1:0];

   // Requantize: arithmetic shift, then clamp to 0..255 using the sign bit and upper bits
   always_comb begin
      q        = $signed(in_data) >>> SHIFT;
      clamp_lo = q[ACC_W-1];
      clamp_hi = !q[ACC_W-1] && (|q[ACC_W-2:8]);
      if (clamp_lo) begin
         score = 8'd0;
      end else if (clamp_hi) begin
         score = 8'd255;
      end else begin
         score = q[7:0];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/pulse outputs decoded from the registered state
   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (hs && last) begin
               state_d = SIGNAL;
            end
         end
         SIGNAL: begin
            frame_done = 1'b1;
            state_d    = frame_release ? FILL : HOLD;
         end
         HOLD: begin
            if (frame_release) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Write counter and score storage
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            entry[i] <= '0;
         end
      end else if (hs) begin
         entry[count] <= score;
         count        <= last ? '0 : count + CNT_W'(1);
      end
   end

   // Registered read port; a same-edge write is not visible until the next read
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_in_range ? entry[rd_idx] : 8'd0;
      end
   end

`ifdef FC2_SAT_FLAG_EN
   // Sticky clamp flag, restarted by the first handshake of each frame
   always_ff @(posedge clk) begin
      if (!rst) begin
         sat_flag <= 1'b0;
      end else if (hs) begin
         sat_flag <= (clamp_lo || clamp_hi) || ((count != '0) && sat_flag);
      end
   end
`endif

endmodule

// File: tb/tb_fc2_score_buffer.sv
// tb_fc2_score_buffer: directed scoreboard bench for fc2_score_buffer.
// Reads push their hand-computed expected score into a queue; a monitor pops
// and compares one cycle after each read address is presented.
// Build with FC2_SAT_FLAG_EN defined to also check sat_flag.
module tb_fc2_score_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_data = '0;
   logic        frame_done;
   logic        frame_release = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [7:0]  rd_data;
`ifdef FC2_SAT_FLAG_EN
   logic        sat_flag;
`endif

   fc2_score_buffer #(
      .NUM_CLASSES(10),
      .ACC_W(24),
      .SHIFT(4),
      .ADDR_W(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .frame_done(frame_done),
      .frame_release(frame_release),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
`ifdef FC2_SAT_FLAG_EN
      ,
      .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   fd_count = 0;
   logic rd_req   = 1'b0;
   logic rd_pend  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Read-data monitor and frame_done pulse counter
   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      exp_t e;
      if (frame_done) fd_count++;
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %0d expected no read", rd_data);
         end else begin
            e = exp_q.pop_front();
            chk(e.name, int'(rd_data), e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int a, input int v, input string n);
      rd_addr = a[9:0];
      rd_req  = 1'b1;
      exp_q.push_back('{n, v});
      step();
      rd_req  = 1'b0;
   endtask

   task automatic send(input int d);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d[23:0];
      for (int i = 0; i < 50 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         step();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nominal[10];
      int sat_exp[10];

      // Reset
      step();
      step();
      rst = 1'b1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      rd(5, 0, "rst_entry5");

      // Nominal frame
      nominal = '{10, 10, 10, 150, 10, 10, 10, 200, 10, 10};
      for (int k = 0; k < 10; k++) begin
         send((k == 3) ? 2400 : (k == 7) ? 3200 : 160);
      end
      chk("nom_frame_done", int'(frame_done), 1);
      chk("nom_signal_ready", int'(in_ready), 0);
      step();
      chk("nom_done_pulse", int'(frame_done), 0);
      for (int k = 0; k < 10; k++) rd(k, nominal[k], $sformatf("nom_rd%0d", k));

      // Backpressure in HOLD
      in_valid = 1'b1;
      in_data  = 24'd1600;
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("bp_ready%0d", k), int'(in_ready), 0);
         step();
      end
      rd(0, 10, "bp_entry0");
      rd(3, 150, "bp_entry3");
      frame_release = 1'b1;
      step();
      frame_release = 1'b0;
      chk("rel_in_ready", int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      rd(0, 100, "bp_held_word");
      chk("fd_after_nom", fd_count, 1);

      // Saturation frame with a read/write collision on entry 2
      sat_exp = '{100, 255, 0, 255, 255, 0, 10, 10, 10, 10};
      send(8000);
      rd_addr = 10'd2;
      rd_req  = 1'b1;
      exp_q.push_back('{"collide_old", 10});
      send(-500);
      rd_req = 1'b0;
      rd(2, 0, "collide_new");
      send(4095);
      send(4096);
      send(15);
      for (int k = 0; k < 4; k++) send(160);
      chk("sat_frame_done", int'(frame_done), 1);
`ifdef FC2_SAT_FLAG_EN
      chk("sat_flag_set", int'(sat_flag), 1);
`endif
      step();
      for (int k = 0; k < 10; k++) rd(k, sat_exp[k], $sformatf("sat_rd%0d", k));
      rd(12, 0, "oor_12");
      rd(9, 10, "pre_oor_9");
      rd(1023, 0, "oor_1023");
      frame_release = 1'b1;
      step();
      frame_release = 1'b0;
      chk("rel2_in_ready", int'(in_ready), 1);

      // Reset mid-fill
      send(800);
      send(800);
      rd(0, 50, "partial_rd0");
      send(800);
      send(800);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("midrst_rd_data", int'(rd_data), 0);
      chk("midrst_frame_done", int'(frame_done), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      for (int k = 0; k < 10; k++) rd(k, 0, $sformatf("midrst_rd%0d", k));
      chk("fd_after_midrst", fd_count, 2);

      // Clean frame, released in its frame_done cycle
      for (int k = 0; k < 10; k++) send(48 * (k + 1));
      chk("clean_frame_done", int'(frame_done), 1);
`ifdef FC2_SAT_FLAG_EN
      chk("sat_flag_clean", int'(sat_flag), 0);
`endif
      frame_release = 1'b1;
      step();
      frame_release = 1'b0;
      chk("signal_rel_ready", int'(in_ready), 1);
      chk("signal_rel_done", int'(frame_done), 0);
      for (int k = 0; k < 10; k++) rd(k, 3 * (k + 1), $sformatf("clean_rd%0d", k));
      step();
      step();
      chk("fd_total", fd_count, 3);
      chk("exp_q_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
